// File: rtl/parking_entry_frontend.sv
// Parking gate front end: sensor synchronise/debounce, serial two-digit keypad
// capture with inter-digit timeout, and lot occupancy tracking with entrance masking.
module parking_entry_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int KEY_TIMEOUT     = 16,
    parameter int CAPACITY        = 8,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entrance_raw,
    input  logic             exit_raw,
    input  logic             depart_raw,
    input  logic             key_valid,
    input  logic [1:0]       key_data,
    input  logic             key_clear,
    output logic             entrance_sensor_input,
    output logic             exit_sensor_input,
    output logic [1:0]       password_1,
    output logic [1:0]       password_2,
    output logic             password_ready,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_W = $clog2(KEY_TIMEOUT + 1);

    typedef enum logic [1:0] {EMPTY, ONE, COMPLETE} key_state_t;

    // Sensor lanes: bit 0 entrance, bit 1 gate exit, bit 2 lot departure.
    logic [2:0]      sync_1, sync_2, level, rise;
    logic [DB_W-1:0] stable_cnt [3];
    logic            exit_pulse, depart_pulse;
    logic [CNT_W-1:0] occ_next;

    key_state_t      state;
    logic [TM_W-1:0] timer;
    logic [1:0]      digit_1, digit_2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two synchroniser stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
            level  <= '0;
            rise   <= '0;
            for (int i = 0; i < 3; i++) stable_cnt[i] <= '0;
        end else begin
            sync_1 <= {depart_raw, exit_raw, entrance_raw};
            sync_2 <= sync_1;
            rise   <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync_2[i] == level[i]) begin
                    stable_cnt[i] <= '0;
                end else if (stable_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]      <= sync_2[i];
                    rise[i]       <= sync_2[i];
                    stable_cnt[i] <= '0;
                end else begin
                    stable_cnt[i] <= stable_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign exit_pulse            = rise[1];
    assign depart_pulse          = rise[2];
    assign exit_sensor_input     = level[1];
    assign entrance_sensor_input = level[0] & ~lot_full;

    // NOTE: occ_next gets a default before any branch so this block never infers a latch.
    always_comb begin
        occ_next = occupancy;
        if (exit_pulse && !depart_pulse && occupancy != CNT_W'(CAPACITY))
            occ_next = occupancy + CNT_W'(1);
        else if (depart_pulse && !exit_pulse && occupancy != '0)
            occ_next = occupancy - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
            lot_full  <= 1'b0;
        end else begin
            occupancy <= occ_next;
            lot_full  <= (occ_next == CNT_W'(CAPACITY));
        end
    end

    // Keypad capture; outputs are registered from the current state, so they
    // follow entry into / exit from COMPLETE by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= EMPTY;
            timer          <= '0;
            digit_1        <= '0;
            digit_2        <= '0;
            password_1     <= '0;
            password_2     <= '0;
            password_ready <= 1'b0;
        end else begin
            password_ready <= (state == COMPLETE);
            password_1     <= (state == COMPLETE) ? digit_1 : 2'b00;
            password_2     <= (state == COMPLETE) ? digit_2 : 2'b00;

            if (key_clear) begin
                state   <= EMPTY;
                timer   <= '0;
                digit_1 <= '0;
                digit_2 <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (key_valid) begin
                            digit_1 <= key_data;
                            timer   <= TM_W'(KEY_TIMEOUT);
                            state   <= ONE;
                        end
                    end
                    ONE: begin
                        if (key_valid) begin
                            digit_2 <= key_data;
                            state   <= COMPLETE;
                        end else if (timer <= TM_W'(1)) begin
                            timer   <= '0;
                            digit_1 <= '0;
                            state   <= EMPTY;
                        end else begin
                            timer <= timer - TM_W'(1);
                        end
                    end
                    COMPLETE: begin
                        // The car that just passed the gate consumes the code.
                        if (exit_pulse) begin
                            digit_1 <= '0;
                            digit_2 <= '0;
                            state   <= EMPTY;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parking_entry_frontend.sv
// Self-checking bench for parking_entry_frontend: completed codes go through a
// scoreboard queue, sensor/occupancy behaviour is checked directly.
module tb_parking_entry_frontend;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             entrance_raw, exit_raw, depart_raw;
    logic             key_valid, key_clear;
    logic [1:0]       key_data;
    logic             entrance_sensor_input, exit_sensor_input;
    logic [1:0]       password_1, password_2;
    logic             password_ready;
    logic [CNT_W-1:0] occupancy;
    logic             lot_full;

    typedef struct {
        logic [1:0] p1;
        logic [1:0] p2;
    } code_t;

    code_t sb[$];
    int    total = 0;
    int    bad   = 0;

    parking_entry_frontend #(
        .DEBOUNCE_CYCLES(4),
        .KEY_TIMEOUT    (16),
        .CAPACITY       (8),
        .CNT_W          (CNT_W)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .entrance_raw         (entrance_raw),
        .exit_raw             (exit_raw),
        .depart_raw           (depart_raw),
        .key_valid            (key_valid),
        .key_data             (key_data),
        .key_clear            (key_clear),
        .entrance_sensor_input(entrance_sensor_input),
        .exit_sensor_input    (exit_sensor_input),
        .password_1           (password_1),
        .password_2           (password_2),
        .password_ready       (password_ready),
        .occupancy            (occupancy),
        .lot_full             (lot_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [1:0] d);
        key_valid = 1'b1;
        key_data  = d;
        tick(1);
        key_valid = 1'b0;
        key_data  = 2'b00;
    endtask

    task automatic clear_code();
        key_clear = 1'b1;
        tick(1);
        key_clear = 1'b0;
    endtask

    task automatic push_code(input logic [1:0] a, input logic [1:0] b);
        code_t c;
        c.p1 = a;
        c.p2 = b;
        sb.push_back(c);
    endtask

    task automatic pulse_exit();
        exit_raw = 1'b1;
        tick(8);
        exit_raw = 1'b0;
        tick(8);
    endtask

    task automatic pulse_depart();
        depart_raw = 1'b1;
        tick(8);
        depart_raw = 1'b0;
        tick(8);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ent"},   entrance_sensor_input, 0);
        check({tag, "_exit"},  exit_sensor_input, 0);
        check({tag, "_pw1"},   password_1, 0);
        check({tag, "_pw2"},   password_2, 0);
        check({tag, "_ready"}, password_ready, 0);
        check({tag, "_occ"},   occupancy, 0);
        check({tag, "_full"},  lot_full, 0);
    endtask

    // Scoreboard: each rising password_ready must match the oldest queued code.
    logic  ready_q = 1'b0;
    code_t exp_code;
    always @(negedge clk) begin
        if (password_ready && !ready_q) begin
            if (sb.size() == 0) begin
                check("unexpected_code", 1, 0);
            end else begin
                exp_code = sb.pop_front();
                check("sb_pw1", password_1, exp_code.p1);
                check("sb_pw2", password_2, exp_code.p2);
            end
        end
        ready_q = password_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_high;
        reset_n      = 1'b0;
        entrance_raw = 1'b0;
        exit_raw     = 1'b0;
        depart_raw   = 1'b0;
        key_valid    = 1'b0;
        key_clear    = 1'b0;
        key_data     = 2'b00;
        tick(3);
        check_all_zero("in_reset");
        reset_n = 1'b1;
        tick(2);
        check_all_zero("post_reset");

        // Clean entrance rise: low for 5 edges, high on the 6th.
        entrance_raw = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check($sformatf("ent_lat_%0d", i), entrance_sensor_input, 0);
        end
        tick(1);
        check("ent_rise", entrance_sensor_input, 1);
        entrance_raw = 1'b0;
        tick(8);
        check("ent_fall", entrance_sensor_input, 0);

        // 3-cycle glitch must not reach the output.
        entrance_raw = 1'b1;
        tick(3);
        entrance_raw = 1'b0;
        seen_high = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (entrance_sensor_input) seen_high = 1;
        end
        check("ent_glitch", seen_high, 0);

        // Two-digit code, second digit three cycles after the first.
        push_code(2'b01, 2'b10);
        key(2'b01);
        tick(2);
        key(2'b10);
        tick(1);
        check("code_ready", password_ready, 1);
        check("code_pw1", password_1, 1);
        check("code_pw2", password_2, 2);
        pulse_exit();
        check("consumed_ready", password_ready, 0);
        check("consumed_pw1", password_1, 0);
        check("consumed_pw2", password_2, 0);
        check("occ_after_exit", occupancy, 1);

        // Inter-digit timeout discards digit 1; the next digit starts a new code.
        key(2'b01);
        tick(20);
        key(2'b10);
        tick(3);
        check("timeout_one_ready", password_ready, 0);
        push_code(2'b10, 2'b11);
        key(2'b11);
        tick(1);
        check("timeout_code_ready", password_ready, 1);
        check("timeout_code_pw1", password_1, 2);
        clear_code();
        tick(1);
        check("clear_ready", password_ready, 0);
        check("clear_pw1", password_1, 0);

        // key_clear beats key_valid in ONE; the next key is then only digit 1.
        key(2'b01);
        key_clear = 1'b1;
        key_valid = 1'b1;
        key_data  = 2'b10;
        tick(1);
        key_clear = 1'b0;
        key_valid = 1'b0;
        key_data  = 2'b00;
        tick(2);
        check("clr_pri_ready", password_ready, 0);
        check("clr_pri_pw1", password_1, 0);
        check("clr_pri_pw2", password_2, 0);
        key(2'b11);
        tick(3);
        check("clr_pri_one_ready", password_ready, 0);
        clear_code();

        // Occupancy: floor at 0, fill to capacity, saturate, unmask on depart.
        pulse_depart();
        check("occ_dec_to_0", occupancy, 0);
        pulse_depart();
        check("occ_floor", occupancy, 0);
        for (int i = 0; i < 8; i++) pulse_exit();
        check("occ_full", occupancy, 8);
        check("lot_full", lot_full, 1);
        entrance_raw = 1'b1;
        tick(8);
        check("ent_masked", entrance_sensor_input, 0);
        pulse_exit();
        check("occ_sat", occupancy, 8);
        check("ent_masked_sat", entrance_sensor_input, 0);
        pulse_depart();
        check("occ_7", occupancy, 7);
        check("lot_not_full", lot_full, 0);
        check("ent_unmasked", entrance_sensor_input, 1);
        entrance_raw = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) pulse_depart();
        check("occ_3", occupancy, 3);
        exit_raw   = 1'b1;
        depart_raw = 1'b1;
        tick(8);
        check("exit_level", exit_sensor_input, 1);
        exit_raw   = 1'b0;
        depart_raw = 1'b0;
        tick(8);
        check("occ_simul", occupancy, 3);

        // Reset mid-debounce with a complete code and nonzero occupancy.
        push_code(2'b01, 2'b11);
        key(2'b01);
        key(2'b11);
        tick(1);
        check("pre_rst_ready", password_ready, 1);
        entrance_raw = 1'b1;
        tick(3);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        tick(2);
        entrance_raw = 1'b0;
        reset_n      = 1'b1;
        tick(2);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
